// File: rtl/arb_pkg.sv
// Shared encodings for the instruction/data RAM port arbiter.
package arb_pkg;

    // Longest RAM read latency the 2-bit wait counter can cover.
    localparam int MEM_LAT_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_D    = 2'b10
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a unified single-port synchronous
// RAM. The fetch port (IR load) and the data port (lw/sw) each hold req until
// their one-cycle ack; every access is issue -> wait latency -> capture -> ack.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner,
    output logic              busy
);

    // The wait counter is two bits wide, so latencies beyond 4 cannot be timed.
    if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_mem_lat
        $error("mem_port_arbiter: MEM_LAT must lie in 1..%0d", MEM_LAT_MAX);
    end

    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    state_t     state;
    owner_t     owner_q;
    owner_t     last_grant;
    logic [1:0] cnt;
    logic       grant_d;

    // Data wins when it is the only requester, or on a conflict when fetch won last time.
    assign grant_d = d_req && (!if_req || (last_grant == OWN_IF));

    assign owner = owner_q;
    assign busy  = (state != ST_IDLE);

    // Access sequencer: grant, one-cycle RAM enable, latency wait, capture and ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner_q    <= OWN_NONE;
            last_grant <= OWN_D;  // first conflict after reset goes to fetch
            cnt        <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
        end else begin
            // NOTE: every state register here uses <= so all branches read the
            // pre-edge values (e.g. ISSUE tests the old mem_we while clearing it).
            unique case (state)
                ST_IDLE: begin
                    if (if_req || d_req) begin
                        mem_en <= 1'b1;
                        state  <= ST_ISSUE;
                        if (grant_d) begin
                            owner_q    <= OWN_D;
                            last_grant <= OWN_D;
                            mem_we     <= d_we;
                            mem_addr   <= d_addr;
                            mem_wdata  <= d_wdata;
                        end else begin
                            owner_q    <= OWN_IF;
                            last_grant <= OWN_IF;
                            mem_we     <= 1'b0;  // fetch is always a read
                            mem_addr   <= if_addr;
                            mem_wdata  <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (mem_we) begin
                        // Stores complete as soon as the RAM has sampled them.
                        d_ack <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt   <= CNT_INIT;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 2'd0) begin
                        if (owner_q == OWN_D) begin
                            d_rdata <= mem_rdata;
                            d_ack   <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ack   <= 1'b1;
                        end
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                ST_DONE: begin
                    if_ack  <= 1'b0;
                    d_ack   <= 1'b0;
                    owner_q <= OWN_NONE;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one DUT with MEM_LAT=1 and one with
// MEM_LAT=3, each in front of a small behavioural synchronous RAM.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // ---------------- DUT with MEM_LAT = 1 ----------------
    logic        if_req, if_ack, d_req, d_we, d_ack, mem_en, mem_we, busy;
    logic [7:0]  if_addr, d_addr, mem_addr;
    logic [31:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
    logic [1:0]  owner;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .owner(owner), .busy(busy)
    );

    // ---------------- DUT with MEM_LAT = 3 ----------------
    logic        if_req_3, if_ack_3, d_req_3, d_we_3, d_ack_3, mem_en_3, mem_we_3, busy_3;
    logic [7:0]  if_addr_3, d_addr_3, mem_addr_3;
    logic [31:0] if_rdata_3, d_wdata_3, d_rdata_3, mem_wdata_3, mem_rdata_3;
    logic [1:0]  owner_3;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req_3), .if_addr(if_addr_3), .if_rdata(if_rdata_3), .if_ack(if_ack_3),
        .d_req(d_req_3), .d_we(d_we_3), .d_addr(d_addr_3), .d_wdata(d_wdata_3),
        .d_rdata(d_rdata_3), .d_ack(d_ack_3),
        .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3),
        .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3),
        .owner(owner_3), .busy(busy_3)
    );

    // ---------------- RAM models ----------------
    function automatic logic [31:0] init_word(input int a);
        case (a)
            4:       return 32'h0050_0093;
            8:       return 32'h1111_1111;
            17:      return 32'h0BAD_C0DE;
            32:      return 32'h1234_5678;
            default: return 32'h0;
        endcase
    endfunction

    logic [31:0] mem1 [256];
    logic [31:0] rd1;
    logic [31:0] mem3 [256];
    logic [31:0] p3 [3];

    // Latency-1 RAM: read word registered on the edge that samples mem_en.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem1[i] <= init_word(i);
            rd1 <= '0;
        end else if (mem_en) begin
            if (mem_we) mem1[mem_addr] <= mem_wdata;
            else        rd1 <= mem1[mem_addr];
        end
    end
    assign mem_rdata = rd1;

    // Latency-3 RAM: the read word passes through two more pipeline registers.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem3[i] <= init_word(i);
            for (int i = 0; i < 3; i++) p3[i] <= '0;
        end else begin
            if (mem_en_3 && mem_we_3)  mem3[mem_addr_3] <= mem_wdata_3;
            if (mem_en_3 && !mem_we_3) p3[0] <= mem3[mem_addr_3];
            p3[1] <= p3[0];
            p3[2] <= p3[1];
        end
    end
    assign mem_rdata_3 = p3[2];

    // ---------------- Handshake / exclusivity monitors ----------------
    logic [1:0] if_hist, d_hist;
    int viol_if = 0;
    int viol_d = 0;
    int both_ack = 0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_hist <= '0;
            d_hist  <= '0;
        end else begin
            if_hist <= {if_hist[0], if_ack};
            d_hist  <= {d_hist[0], d_ack};
            if ((if_ack && d_ack) || (if_ack_3 && d_ack_3)) both_ack <= both_ack + 1;
        end
    end

    // A req still high at the IDLE sampling edge two edges after its ack rose.
    always @(posedge clk) begin
        if (rst_n) begin
            if (if_hist[1] && if_req) viol_if <= viol_if + 1;
            if (d_hist[1] && d_req)   viol_d  <= viol_d + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- Helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Data access on dut1; lat = ticks from req until ack seen (0 = timeout).
    task automatic d_access(input logic we, input logic [7:0] addr,
                            input logic [31:0] wdata, output int lat);
        d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1; lat = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (d_ack) begin lat = i; break; end
        end
        d_req = 1'b0; d_we = 1'b0;
        tick(); tick();
    endtask

    task automatic if_access(input logic [7:0] addr, output int lat);
        if_addr = addr; if_req = 1'b1; lat = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (if_ack) begin lat = i; break; end
        end
        if_req = 1'b0;
        tick(); tick();
    endtask

    task automatic wait_grant(output logic [1:0] own);
        own = 2'b11;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (mem_en) begin own = owner; break; end
        end
    endtask

    task automatic wait_if_ack(output bit seen);
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (if_ack) begin seen = 1; break; end
        end
    endtask

    task automatic wait_d_ack(output bit seen);
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (d_ack) begin seen = 1; break; end
        end
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        if_req_3 = 0; if_addr_3 = 0; d_req_3 = 0; d_we_3 = 0; d_addr_3 = 0; d_wdata_3 = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({if_ack, d_ack, mem_en, mem_we, owner, busy} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl_lat1 got=%b exp=0", {if_ack, d_ack, mem_en, mem_we, owner, busy});
        end
        checks++;
        if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== 104'b0) begin
            failures++;
            $display("FAIL reset_data_lat1 got=%h exp=0", {if_rdata, d_rdata, mem_addr, mem_wdata});
        end
        checks++;
        if ({if_ack_3, d_ack_3, mem_en_3, mem_we_3, owner_3, busy_3} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl_lat3 got=%b exp=0", {if_ack_3, d_ack_3, mem_en_3, mem_we_3, owner_3, busy_3});
        end
        checks++;
        if ({if_rdata_3, d_rdata_3, mem_addr_3, mem_wdata_3} !== 104'b0) begin
            failures++;
            $display("FAIL reset_data_lat3 got=%h exp=0", {if_rdata_3, d_rdata_3, mem_addr_3, mem_wdata_3});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        if_addr = 8'h04; if_req = 1'b1;
        tick();  // window E0-E1
        checks++;
        if ({mem_en, mem_we, owner, busy} !== 5'b1_0_01_1) begin
            failures++;
            $display("FAIL fetch_issue en/we/owner/busy got=%b exp=10011", {mem_en, mem_we, owner, busy});
        end
        checks++;
        if (mem_addr !== 8'h04) begin
            failures++;
            $display("FAIL fetch_addr got=%h exp=04", mem_addr);
        end
        tick();  // window E1-E2
        checks++;
        if ({mem_en, if_ack, owner} !== 4'b0_0_01) begin
            failures++;
            $display("FAIL fetch_wait en/ack/owner got=%b exp=0001", {mem_en, if_ack, owner});
        end
        tick();  // window E2-E3
        checks++;
        if ({if_ack, d_ack, if_rdata} !== {2'b10, 32'h0050_0093}) begin
            failures++;
            $display("FAIL fetch_ack ack=%b%b rdata=%h exp ack=10 rdata=00500093", if_ack, d_ack, if_rdata);
        end
        if_req = 1'b0;
        tick();  // window E3-E4
        checks++;
        if ({if_ack, owner, busy} !== 4'b0) begin
            failures++;
            $display("FAIL fetch_done ack/owner/busy got=%b exp=0000", {if_ack, owner, busy});
        end
        tick();
    endtask

    task automatic test_store();
        int lat;
        d_access(1'b0, 8'h11, 32'h0, lat);
        checks++;
        if (lat !== 3 || d_rdata !== 32'h0BAD_C0DE) begin
            failures++;
            $display("FAIL load_11 lat=%0d rdata=%h exp lat=3 rdata=0badc0de", lat, d_rdata);
        end
        d_we = 1'b1; d_addr = 8'h10; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
        tick();  // window E0-E1
        checks++;
        if ({mem_en, mem_we, owner} !== 4'b1_1_10) begin
            failures++;
            $display("FAIL store_issue en/we/owner got=%b exp=1110", {mem_en, mem_we, owner});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== {8'h10, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL store_addr_data got=%h exp=10deadbeef", {mem_addr, mem_wdata});
        end
        tick();  // window E1-E2
        checks++;
        if ({d_ack, mem_en, mem_we} !== 3'b100) begin
            failures++;
            $display("FAIL store_ack ack/en/we got=%b exp=100", {d_ack, mem_en, mem_we});
        end
        checks++;
        if (d_rdata !== 32'h0BAD_C0DE) begin
            failures++;
            $display("FAIL store_keeps_rdata got=%h exp=0badc0de", d_rdata);
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();  // window E2-E3
        checks++;
        if ({d_ack, busy} !== 2'b00) begin
            failures++;
            $display("FAIL store_done ack/busy got=%b exp=00", {d_ack, busy});
        end
        tick();
        d_access(1'b0, 8'h10, 32'h0, lat);
        checks++;
        if (lat !== 3 || d_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL load_after_store lat=%0d rdata=%h exp lat=3 rdata=deadbeef", lat, d_rdata);
        end
        checks++;
        if (mem1[16] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL ram_written got=%h exp=deadbeef", mem1[16]);
        end
    endtask

    task automatic test_conflict();
        logic [1:0] own;
        bit seen;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int r = 0; r < 2; r++) begin
            if_addr = 8'h04; d_addr = 8'h11; d_we = 1'b0;
            if_req = 1'b1; d_req = 1'b1;
            wait_grant(own);
            checks++;
            if (own !== 2'b01) begin
                failures++;
                $display("FAIL conflict_first round=%0d owner=%b exp=01", r, own);
            end
            wait_if_ack(seen);
            if_req = 1'b0;
            checks++;
            if (!seen || if_rdata !== 32'h0050_0093) begin
                failures++;
                $display("FAIL conflict_fetch_data round=%0d acked=%0d rdata=%h exp=00500093", r, seen, if_rdata);
            end
            wait_grant(own);
            checks++;
            if (own !== 2'b10) begin
                failures++;
                $display("FAIL conflict_second round=%0d owner=%b exp=10", r, own);
            end
            wait_d_ack(seen);
            d_req = 1'b0;
            checks++;
            if (!seen || d_rdata !== 32'h0BAD_C0DE) begin
                failures++;
                $display("FAIL conflict_data round=%0d acked=%0d rdata=%h exp=0badc0de", r, seen, d_rdata);
            end
            tick(); tick();
        end
    endtask

    task automatic test_lat3();
        logic exp_b, exp_a;
        d_addr_3 = 8'h20; d_we_3 = 1'b0; d_req_3 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();  // window E(k-1)-E(k)
            exp_b = (k <= 5);
            exp_a = (k == 5);
            checks++;
            if (busy_3 !== exp_b) begin
                failures++;
                $display("FAIL lat3_busy window=%0d got=%b exp=%b", k - 1, busy_3, exp_b);
            end
            checks++;
            if (d_ack_3 !== exp_a) begin
                failures++;
                $display("FAIL lat3_ack window=%0d got=%b exp=%b", k - 1, d_ack_3, exp_a);
            end
            if (d_ack_3) d_req_3 = 1'b0;
        end
        d_req_3 = 1'b0;
        checks++;
        if (d_rdata_3 !== 32'h1234_5678) begin
            failures++;
            $display("FAIL lat3_rdata got=%h exp=12345678", d_rdata_3);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        int lat;
        if_addr = 8'h08; if_req = 1'b1;
        tick();  // ISSUE
        tick();  // WAIT
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_en, owner, if_ack, busy} !== 5'b0) begin
            failures++;
            $display("FAIL midreset_ctrl en/owner/ack/busy got=%b exp=00000", {mem_en, owner, if_ack, busy});
        end
        checks++;
        if ({if_rdata, d_rdata} !== 64'h0) begin
            failures++;
            $display("FAIL midreset_rdata got=%h exp=0", {if_rdata, d_rdata});
        end
        if_req = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (if_ack || d_ack) stale++;
        end
        checks++;
        if (stale !== 0) begin
            failures++;
            $display("FAIL midreset_stale_ack got=%0d exp=0", stale);
        end
        if_access(8'h08, lat);
        checks++;
        if (lat !== 3 || if_rdata !== 32'h1111_1111) begin
            failures++;
            $display("FAIL midreset_refetch lat=%0d rdata=%h exp lat=3 rdata=11111111", lat, if_rdata);
        end
    endtask

    task automatic test_back_to_back_violation();
        int en_cnt = 0;
        int ack_cnt = 0;
        int first_ack = -1;
        int viol_before;
        checks++;
        if (viol_if !== 0 || viol_d !== 0) begin
            failures++;
            $display("FAIL handshake_clean_so_far if=%0d d=%0d exp=0/0", viol_if, viol_d);
        end
        viol_before = viol_d;
        d_we = 1'b1; d_addr = 8'h30; d_wdata = 32'hA5A5_A5A5; d_req = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (mem_en) en_cnt++;
            if (d_ack) begin
                ack_cnt++;
                if (first_ack < 0) first_ack = j;
            end
            // Hold req one cycle past the deadline: still high at the next IDLE sample.
            if (first_ack >= 0 && j == first_ack + 2) begin
                d_req = 1'b0; d_we = 1'b0;
            end
        end
        d_req = 1'b0; d_we = 1'b0;
        checks++;
        if (en_cnt !== 2) begin
            failures++;
            $display("FAIL repeat_access mem_en_pulses=%0d exp=2", en_cnt);
        end
        checks++;
        if (ack_cnt !== 2) begin
            failures++;
            $display("FAIL repeat_access d_ack_pulses=%0d exp=2", ack_cnt);
        end
        checks++;
        if (viol_d - viol_before !== 1) begin
            failures++;
            $display("FAIL handshake_flagged violations=%0d exp=1", viol_d - viol_before);
        end
        checks++;
        if (mem1[48] !== 32'hA5A5_A5A5) begin
            failures++;
            $display("FAIL repeat_store_ram got=%h exp=a5a5a5a5", mem1[48]);
        end
        checks++;
        if (both_ack !== 0) begin
            failures++;
            $display("FAIL ack_exclusive overlaps=%0d exp=0", both_ack);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_conflict();
        test_lat3();
        test_reset_mid();
        test_back_to_back_violation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between two requesters: the instruction-fetch port (S1 / IR_Write path of the multi-cycle CPU) and the data port (lw/sw path, S8/S10).
- Sequences each access: issue, wait for read latency, capture, acknowledge.
- Resolves simultaneous requests round-robin.
- Sits between the control-unit/datapath and the unified instruction/data RAM.

Parameters:
- ADDR_W, 8, word-address width of the RAM.
- DATA_W, 32, data width.
- MEM_LAT, 1, RAM read latency in cycles, counted from the edge that samples mem_en; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch word address.
- if_rdata  out  DATA_W  fetched instruction; registered.
- if_ack  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = store (sw), 0 = load (lw).
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; registered.
- d_ack  out  1  one-cycle completion pulse for data.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data.
- owner  out  2  00 none, 01 fetch, 10 data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
Reset:
- Asynchronous, active-low.
- All outputs 0; state IDLE; last_grant = DATA, so the first conflict grants fetch.
- Reset mid-transaction aborts it: no ack, mem_en drops immediately, rdata registers cleared.

Output timing:
- All outputs are registered; none is combinational from inputs.

States:
- IDLE:
  - Only d_req: grant data.
  - Only if_req: grant fetch.
  - Both: grant the port opposite last_grant; update last_grant.
  - On grant: latch addr/we/wdata of the winner into mem_* (fetch forces mem_we=0); mem_en<=1; owner set; go ISSUE.
- ISSUE (mem_en high exactly this one cycle):
  - mem_en<=0.
  - Write: d_ack<=1, go DONE.
  - Read: cnt<=MEM_LAT-1, go WAIT.
- WAIT:
  - cnt==0: capture mem_rdata into if_rdata or d_rdata per owner; ack<=1; go DONE.
  - Otherwise: cnt decrements.
- DONE:
  - ack<=0, owner<=00, go IDLE.

Latency (req sampled at edge E0):
- Store ack is high between E1 and E2.
- Read ack is high between E(1+MEM_LAT) and E(2+MEM_LAT).
- Throughput: one store per 3 cycles; one read per MEM_LAT+3 cycles.

Handshake:
- Requester must deassert req before the edge that ends the cycle after ack, i.e. before IDLE next samples. Violation causes a repeat access; this is a requester bug, and the bench asserts it.
- Inputs of the granted port are ignored after the grant edge; inputs of the losing port are ignored until it is granted.
- A request arriving while busy waits; there is no queue beyond the held req.

Other rules:
- rdata registers hold their value until the next read by the same port; a store never changes d_rdata.
- Only one ack is ever high per cycle; if_ack and d_ack are never high together.
- MEM_LAT outside 1..4: elaboration error.
- cnt width = 2 bits.

Decomposition:
- Shared package arb_pkg:
  - state encoding (IDLE/ISSUE/WAIT/DONE, 2 bits);
  - owner encoding (NONE/IF/D);
  - constant MEM_LAT_MAX = 4.
- Monolithic module; no sub-module is natural. The round-robin pick is a two-line expression.

Test Plan:
- Fetch only, MEM_LAT=1, RAM[0x04]=0x00500093, if_req at E0 -> mem_en high E0–E1 with addr 0x04, we=0; if_ack high E2–E3; if_rdata=0x00500093; owner 01 until E3.
- Store, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF -> mem_en=mem_we=1 for one cycle; d_ack high E1–E2; a following load of 0x10 returns 0xDEADBEEF; d_rdata unchanged by the store.
- if_req and d_req both high from reset -> fetch served first, data second; repeat the conflict -> grants alternate fetch, data, fetch.
- MEM_LAT=3, data load of 0x20 holding 0x12345678 -> d_ack high E4–E5; d_rdata=0x12345678; busy high E0–E5.
- rst_n low during WAIT of a fetch -> mem_en, owner, if_ack, if_rdata, busy all 0 immediately; after release a new if_req completes normally with no stale ack.
- d_req held high one cycle too long after d_ack -> a second identical access is issued; the bench assertion for the handshake rule flags it.
